register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the CPU core. It supports N read ports and M write ports, with write-to-read bypass on every read port and deterministic write priority. A hardware clear sequencer zeroes the whole file after reset, and a registered collision flag reports same-cycle writes to one register. It replaces the 2R/1W file in the decode/writeback path and allows dual-issue experiments.

Parameters:
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 1, number of write ports (1..2)
XLEN, from cpu_core_params.vh (32), data width
REG_ADDR_WIDTH, from cpu_core_params.vh (5), address width; DEPTH = 1<<REG_ADDR_WIDTH

Ports:
i_Clock  in  1  core clock, all state on rising edge
i_Reset_n  in  1  synchronous active-low reset
i_Enable  in  1  block enable; gates reads and writes, not the clear sweep
i_Read_Addr  in  NUM_READ*REG_ADDR_WIDTH  packed read addresses, port k at [k*RAW +: RAW]
o_Read_Data  out  NUM_READ*XLEN  packed read data, port k at [k*XLEN +: XLEN]
i_Write_Addr  in  NUM_WRITE*REG_ADDR_WIDTH  packed write addresses
i_Write_Data  in  NUM_WRITE*XLEN  packed write data
i_Write_Enable  in  NUM_WRITE  per-port write enable
o_Ready  out  1  high when the clear sweep is done and the file accepts traffic
o_Write_Collision  out  1  registered pulse: previous cycle had ≥2 effective writes to the same register

Behaviour:
- Effective write, port j: i_Enable && o_Ready && i_Write_Enable[j] && addr_j != 0.
- Register x0 has no storage. Reads of x0 always return 0. Writes to x0 are dropped silently.
- FSM states: CLEAR and READY.
  - i_Reset_n==0 at a clock edge → state<=CLEAR, Clear_Idx<=1, o_Write_Collision<=0.
  - In CLEAR, each cycle after reset is released: Registers[Clear_Idx]<=0 and Clear_Idx increments.
  - After the cycle that writes index DEPTH-1, state<=READY. The sweep therefore takes DEPTH-1 cycles after reset deasserts (31 for the default).
  - The sweep advances regardless of i_Enable.
  - Reset asserted mid-sweep restarts the sweep at index 1.
  - o_Ready = (state==READY), registered. It is 0 during reset and throughout CLEAR.
- While !o_Ready: all writes are ignored and every o_Read_Data lane is 0.
- Read port k, combinational, zero latency:
  - Output is 0 if !i_Enable, !o_Ready, or addr_k==0.
  - Otherwise, if any effective write matches addr_k, output that write's data (highest matching j).
  - Otherwise output Registers[addr_k].
- Write priority: if several effective writes target the same address, the highest port index wins, both for storage and for bypass.
- Storage is updated on the rising edge; new data is visible through the array from the next cycle and through the bypass in the same cycle.
- o_Write_Collision: registered.
  - Set to 1 for exactly one cycle following any cycle with ≥2 effective writes to an identical nonzero address.
  - 0 otherwise; always 0 when NUM_WRITE==1.
- Reset values: o_Ready=0, o_Write_Collision=0, o_Read_Data=0. Array contents are undefined until the sweep completes; they are never observable, because reads are forced to 0 while !o_Ready.
- Distinct-address writes on different ports in the same cycle all commit.

Decomposition:
- XLEN and REG_ADDR_WIDTH stay in cpu_core_params.vh.
- Add to the same shared header: the localparam state encodings RF_STATE_CLEAR=1'b0 and RF_STATE_READY=1'b1, and RF_DEPTH.
- One natural sub-module, register_file_read_port. It holds the combinational bypass/priority mux for a single read lane and is instantiated NUM_READ times via generate.
- The FSM, array, write-priority logic and collision detect live in the top module.

Test Plan:
- Reset held 3 cycles, then released → o_Ready=0 for exactly 31 cycles, then 1; reads of x1..x31 return 0.
- Assert reset at sweep cycle 10 for 1 cycle → o_Ready stays 0 for a further 31 cycles from release.
- Ready; write port0 x5=0xDEADBEEF with read port1 on x5 in the same cycle → o_Read_Data[1]=0xDEADBEEF that cycle (bypass), and again next cycle from the array.
- NUM_WRITE=2; port0 x7=0x11, port1 x7=0x22 in the same cycle → bypass returns 0x22, x7 reads 0x22 next cycle, o_Write_Collision=1 for one cycle only.
- Write x0=0xFFFFFFFF on both ports → reads of x0 return 0, o_Write_Collision stays 0.
- i_Enable=0 with write x3=0x55 → reads return 0, and x3 is unchanged after i_Enable returns to 1.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared core parameters and register-file constants used by the register
// file and its read-port lanes.
package register_file_mp_pkg;

    localparam int CORE_XLEN           = 32;
    localparam int CORE_REG_ADDR_WIDTH = 5;
    localparam int RF_DEPTH            = 1 << CORE_REG_ADDR_WIDTH;

    typedef enum logic {
        RF_STATE_CLEAR = 1'b0,
        RF_STATE_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/register_file_read_port.sv
// One read lane: returns the array value for its address unless a same-cycle
// effective write targets that address, in which case the highest-indexed
// matching write port's data is forwarded. Forced to 0 when the lane is not
// valid (disabled or not ready) or when addressing x0.
module register_file_read_port #(
    parameter int NUM_WRITE      = 1,
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                               read_valid,
    input  logic [REG_ADDR_WIDTH-1:0]          read_addr,
    input  logic [XLEN-1:0]                    array_data,
    input  logic [NUM_WRITE-1:0]               wr_valid,
    input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0]          wr_data,
    output logic [XLEN-1:0]                    read_data
);

    // Bypass mux; later (higher) write ports override earlier ones.
    always_comb begin
        // NOTE: default assignment first so every path drives read_data and no latch is inferred.
        read_data = '0;
        if (read_valid && (read_addr != '0)) begin
            read_data = array_data;
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wr_valid[j] && (wr_addr[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == read_addr)) begin
                    read_data = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NUM_READ combinational read lanes with
// write bypass, NUM_WRITE write ports with highest-port-wins priority, a
// post-reset clear sweep of x1..x(DEPTH-1), and a registered collision flag.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NUM_READ       = 2,
    parameter int NUM_WRITE      = 1,
    parameter int XLEN           = CORE_XLEN,
    parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset_n,
    input  logic                                i_Enable,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0]  i_Read_Addr,
    output logic [NUM_READ*XLEN-1:0]            o_Read_Data,
    input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0] i_Write_Addr,
    input  logic [NUM_WRITE*XLEN-1:0]           i_Write_Data,
    input  logic [NUM_WRITE-1:0]                i_Write_Enable,
    output logic                                o_Ready,
    output logic                                o_Write_Collision
);

    localparam int RAW   = REG_ADDR_WIDTH;
    localparam int DEPTH = 1 << RAW;

    rf_state_e            state;
    logic [RAW-1:0]       clear_idx;
    logic [XLEN-1:0]      regs [1:DEPTH-1];
    logic [NUM_WRITE-1:0] wr_eff;
    logic                 collision_d;
    logic                 read_valid;

    // The state flop itself is the registered ready indication.
    assign o_Ready    = (state == RF_STATE_READY);
    assign read_valid = i_Enable && o_Ready;

    // Effective write qualification per port; x0 writes are dropped here.
    always_comb begin
        wr_eff = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            wr_eff[j] = read_valid && i_Write_Enable[j] && (i_Write_Addr[j*RAW +: RAW] != '0);
        end
    end

    // Any pair of effective writes to one register this cycle.
    always_comb begin
        collision_d = 1'b0;
        for (int a = 0; a < NUM_WRITE; a++) begin
            for (int b = a + 1; b < NUM_WRITE; b++) begin
                if (wr_eff[a] && wr_eff[b] &&
                    (i_Write_Addr[a*RAW +: RAW] == i_Write_Addr[b*RAW +: RAW])) begin
                    collision_d = 1'b1;
                end
            end
        end
    end

    // Clear-sweep FSM and registered collision pulse.
    always_ff @(posedge i_Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!i_Reset_n) begin
            state             <= RF_STATE_CLEAR;
            clear_idx         <= RAW'(1);
            o_Write_Collision <= 1'b0;
        end else begin
            o_Write_Collision <= collision_d;
            if (state == RF_STATE_CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
                if (clear_idx == RAW'(DEPTH - 1)) begin
                    state <= RF_STATE_READY;
                end
            end
        end
    end

    // Storage: zeroed by the sweep, then written in ascending port order so the highest port wins.
    always_ff @(posedge i_Clock) begin
        // NOTE: the array has no reset branch; the sweep clears it and reads are masked until it finishes.
        if (i_Reset_n) begin
            if (state == RF_STATE_CLEAR) begin
                regs[clear_idx] <= '0;
            end else begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wr_eff[j]) begin
                        regs[i_Write_Addr[j*RAW +: RAW]] <= i_Write_Data[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // One bypass lane per read port.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [RAW-1:0]  addr;
        logic [XLEN-1:0] array_data;

        assign addr       = i_Read_Addr[k*RAW +: RAW];
        assign array_data = (addr == '0) ? '0 : regs[addr];

        register_file_read_port #(
            .NUM_WRITE      (NUM_WRITE),
            .XLEN           (XLEN),
            .REG_ADDR_WIDTH (RAW)
        ) u_read_port (
            .read_valid (read_valid),
            .read_addr  (addr),
            .array_data (array_data),
            .wr_valid   (wr_eff),
            .wr_addr    (i_Write_Addr),
            .wr_data    (i_Write_Data),
            .read_data  (o_Read_Data[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp with two read and two write ports.
module tb_register_file_mp;

    localparam int NR  = 2;
    localparam int NW  = 2;
    localparam int XL  = 32;
    localparam int RAW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [NR*RAW-1:0] read_addr;
    logic [NR*XL-1:0]  read_data;
    logic [NW*RAW-1:0] write_addr;
    logic [NW*XL-1:0]  write_data;
    logic [NW-1:0]     write_enable;
    logic              ready;
    logic              collision;

    register_file_mp #(
        .NUM_READ       (NR),
        .NUM_WRITE      (NW),
        .XLEN           (XL),
        .REG_ADDR_WIDTH (RAW)
    ) dut (
        .i_Clock           (clk),
        .i_Reset_n         (rst_n),
        .i_Enable          (enable),
        .i_Read_Addr       (read_addr),
        .o_Read_Data       (read_data),
        .i_Write_Addr      (write_addr),
        .i_Write_Data      (write_data),
        .i_Write_Enable    (write_enable),
        .o_Ready           (ready),
        .o_Write_Collision (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          lane;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [0:31];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_read(input string tag, input int lane, input logic [31:0] e);
        exp_t x;
        x.tag  = tag;
        x.lane = lane;
        x.exp  = e;
        sb.push_back(x);
    endtask

    // Compare every queued read expectation at the falling edge.
    task automatic drain();
        exp_t x;
        @(negedge clk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.tag, read_data[x.lane*XL +: XL], x.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_io(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] ra0, input logic [4:0] ra1);
        write_enable = we;
        write_addr   = {a1, a0};
        write_data   = {d1, d0};
        read_addr    = {ra1, ra0};
    endtask

    // Ready must stay low for exactly 31 cycles after release, lanes read 0.
    task automatic check_sweep(input string tag);
        for (int i = 0; i < 31; i++) begin
            check({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
            set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(i + 1), 5'(31 - i));
            expect_read({tag, "_rd0"}, 0, 32'd0);
            expect_read({tag, "_rd1"}, 1, 32'd0);
            drain();
            step();
        end
        check({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic        we0, we1, en, e0, e1, coll_exp;
        logic [4:0]  a0, a1, ra0, ra1;
        logic [31:0] d0, d1, x0, x1;

        rst_n  = 1'b0;
        enable = 1'b1;
        set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd1);

        // Reset held three cycles.
        repeat (3) step();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_coll", {31'd0, collision}, 32'd0);
        expect_read("reset_rd0", 0, 32'd0);
        expect_read("reset_rd1", 1, 32'd0);
        drain();
        step();

        rst_n = 1'b1;
        check_sweep("sweep1");

        // Restart the sweep: reset, release, then reset again at sweep cycle 10.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("mid_sweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_sweep("sweep2");

        // Whole array is zero after the sweep.
        for (int a = 1; a < 32; a++) begin
            set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'(a), 5'(32 - a));
            expect_read("cleared_rd0", 0, 32'd0);
            expect_read("cleared_rd1", 1, 32'd0);
            drain();
            step();
        end

        // Bypass then array read of x5.
        set_io(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 5'd5);
        expect_read("x5_bypass", 1, 32'hDEADBEEF);
        expect_read("x0_lane0", 0, 32'd0);
        drain();
        step();
        set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        expect_read("x5_array0", 0, 32'hDEADBEEF);
        expect_read("x5_array1", 1, 32'hDEADBEEF);
        drain();
        check("x5_no_coll", {31'd0, collision}, 32'd0);
        step();

        // Same-register writes on both ports: port 1 wins, one-cycle collision.
        set_io(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd5);
        expect_read("x7_bypass", 0, 32'h22);
        expect_read("x5_keep", 1, 32'hDEADBEEF);
        drain();
        step();
        set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd7);
        check("x7_coll_pulse", {31'd0, collision}, 32'd1);
        expect_read("x7_array", 0, 32'h22);
        drain();
        step();
        check("x7_coll_clear", {31'd0, collision}, 32'd0);

        // Both ports write x0: dropped, no collision.
        set_io(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_read("x0_rd0", 0, 32'd0);
        expect_read("x0_rd1", 1, 32'd0);
        drain();
        step();
        check("x0_no_coll", {31'd0, collision}, 32'd0);

        // Disabled block: reads 0 and the write to x3 is ignored.
        enable = 1'b0;
        set_io(2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 5'd3, 5'd5);
        expect_read("dis_rd0", 0, 32'd0);
        expect_read("dis_rd1", 1, 32'd0);
        drain();
        step();
        enable = 1'b1;
        set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd5);
        expect_read("x3_unchanged", 0, 32'd0);
        expect_read("x5_after_dis", 1, 32'hDEADBEEF);
        drain();
        step();

        // Distinct addresses on both ports both commit.
        set_io(2'b11, 5'd9, 32'hA5A5_0009, 5'd10, 32'h5A5A_000A, 5'd9, 5'd10);
        expect_read("x9_bypass", 0, 32'hA5A5_0009);
        expect_read("x10_bypass", 1, 32'h5A5A_000A);
        drain();
        step();
        set_io(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd10);
        check("distinct_no_coll", {31'd0, collision}, 32'd0);
        expect_read("x9_array", 0, 32'hA5A5_0009);
        expect_read("x10_array", 1, 32'h5A5A_000A);
        drain();
        step();

        // Randomised traffic against a reference model of the file.
        for (int a = 0; a < 32; a++) mdl[a] = 32'd0;
        mdl[5]  = 32'hDEADBEEF;
        mdl[7]  = 32'h22;
        mdl[9]  = 32'hA5A5_0009;
        mdl[10] = 32'h5A5A_000A;
        for (int n = 0; n < 200; n++) begin
            en  = ($urandom_range(0, 3) != 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            a0  = 5'($urandom_range(0, 15));
            a1  = 5'($urandom_range(0, 15));
            ra0 = 5'($urandom_range(0, 15));
            ra1 = 5'($urandom_range(0, 15));
            d0  = $urandom;
            d1  = $urandom;
            enable = en;
            set_io({we1, we0}, a0, d0, a1, d1, ra0, ra1);
            e0 = en && we0 && (a0 != 5'd0);
            e1 = en && we1 && (a1 != 5'd0);
            x0 = (!en || ra0 == 5'd0) ? 32'd0 : (e1 && a1 == ra0) ? d1 : (e0 && a0 == ra0) ? d0 : mdl[ra0];
            x1 = (!en || ra1 == 5'd0) ? 32'd0 : (e1 && a1 == ra1) ? d1 : (e0 && a0 == ra1) ? d0 : mdl[ra1];
            coll_exp = e0 && e1 && (a0 == a1);
            expect_read("rand_rd0", 0, x0);
            expect_read("rand_rd1", 1, x1);
            drain();
            if (e0) mdl[a0] = d0;
            if (e1) mdl[a1] = d1;
            step();
            check("rand_coll", {31'd0, collision}, {31'd0, coll_exp});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
